// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle 32-bit shifter that uses coarse 4-bit steps, then 1-bit steps.
// Ports:
//   clock   - rising-edge clock
//   resetn  - asynchronous active-low reset
//   start   - request, sampled only while ready=1
//   data_in - operand to shift
//   shamt   - shift amount 0..31
//   op      - 00 SLL, 01 SRA, 10 SRL, 11 SLL
//   ready   - high while idle and able to accept a request
//   done    - one-cycle pulse when result becomes valid
//   result  - shifted value, held until the next done
module seq_shift_unit #(
    parameter int WIDTH  = 32,
    parameter int COARSE = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       shamt,
    input  logic [1:0]       op,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [4:0]       cnt;
    logic [4:0]       step;
    logic [1:0]       op_q;

    // Take a coarse step while at least COARSE bits remain, otherwise a single bit.
    always_comb begin
        step     = (cnt >= 5'(COARSE)) ? 5'(COARSE) : 5'd1;
        acc_next = (op_q == 2'b01) ? WIDTH'($signed(acc) >>> step) :
                   (op_q == 2'b10) ? acc >> step : acc << step;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    acc   <= data_in;
                    cnt   <= shamt;
                    op_q  <= op;
                    ready <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: if (cnt == 5'd0) begin
                    result <= acc;
                    done   <= 1'b1;
                    state  <= DONE;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt - step;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed self-checking bench for seq_shift_unit.
module tb_seq_shift_unit;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  op = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    int          errors = 0;
    int          checks = 0;

    seq_shift_unit dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .data_in(data_in),
        .shamt  (shamt),
        .op     (op),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts one request at edge E and checks done/ready timing edge by edge and the result.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] o, input int n, input logic [31:0] exp);
        @(negedge clock);
        chk({tag, " ready_before"}, 32'(ready), 32'd1);
        start = 1'b1; data_in = d; shamt = s; op = o;
        @(posedge clock);
        #1;
        start = 1'b0; data_in = ~d; shamt = ~s; op = ~o;
        for (int i = 1; i <= n + 1; i++) begin
            @(posedge clock);
            #1;
            chk({tag, " ready_low"}, 32'(ready), 32'd0);
            chk({tag, " done"}, 32'(done), (i == n + 1) ? 32'd1 : 32'd0);
        end
        chk({tag, " result"}, result, exp);
        @(posedge clock);
        #1;
        chk({tag, " ready_after"}, 32'(ready), 32'd1);
        chk({tag, " done_after"}, 32'(done), 32'd0);
        chk({tag, " result_held"}, result, exp);
    endtask

    initial begin
        #12;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'h0);
        @(negedge clock);
        resetn = 1'b1;

        run_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 10, 32'h8000_0000);
        run_op("sra4", 32'h8000_0000, 5'd4, 2'b01, 1, 32'hF800_0000);
        run_op("sra6", 32'hF0F0_0000, 5'd6, 2'b01, 3, 32'hFFC3_C000);
        run_op("srl31", 32'h8000_0000, 5'd31, 2'b10, 10, 32'h0000_0001);
        run_op("op11", 32'h0000_00FF, 5'd8, 2'b11, 2, 32'h0000_FF00);
        run_op("sham0", 32'hDEAD_BEEF, 5'd0, 2'b01, 0, 32'hDEAD_BEEF);
        run_op("srl3", 32'h8000_0001, 5'd3, 2'b10, 3, 32'h1000_0000);

        // start held high: first request runs, the second is taken at the first ready edge
        @(negedge clock);
        start = 1'b1; data_in = 32'h0000_0001; shamt = 5'd9; op = 2'b00;
        @(posedge clock);
        #1;
        data_in = 32'h0000_0003; shamt = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            chk("hold_busy_done", 32'(done), 32'd0);
        end
        @(posedge clock);
        #1;
        chk("hold_first_done", 32'(done), 32'd1);
        chk("hold_first_result", result, 32'h0000_0200);
        @(posedge clock);
        #1;
        chk("hold_ready", 32'(ready), 32'd1);
        @(posedge clock);
        #1;
        chk("hold_second_accept", 32'(ready), 32'd0);
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("hold_second_busy", 32'(done), 32'd0);
        @(posedge clock);
        #1;
        chk("hold_second_done", 32'(done), 32'd1);
        chk("hold_second_result", result, 32'h0000_0030);
        @(posedge clock);
        #1;

        // reset in the middle of a shamt=20 operation
        @(negedge clock);
        start = 1'b1; data_in = 32'h0000_0001; shamt = 5'd20; op = 2'b00;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_busy", 32'(ready), 32'd0);
        resetn = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        chk("abort_idle", 32'(ready), 32'd1);
        run_op("post_reset", 32'h8000_0000, 5'd31, 2'b10, 10, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
